seg_scan_capture: RTL

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

---
 rtl/seg_scan_capture.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
// Watches a multiplexed 8-digit, active-low seven-segment display bus and
// reconstructs the hex value being shown. Each digit is captured once its
// anode/segment/dp pattern has been stable for STABLE_CYCLES registered
// samples. A frame pulse is raised once every digit has been captured.

module seg_scan_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  anodes,
   input  logic [6:0]  segments,
   input  logic        dp,
   output logic [31:0] digit_val,
   output logic [7:0]  digit_ok,
   output logic [7:0]  dp_bits,
   output logic [2:0]  cur_idx,
   output logic        frame_done,
   output logic        anode_err
);

   localparam logic [3:0] cntMax = 4'(STABLE_CYCLES);
   localparam logic [3:0] cntPre = 4'(STABLE_CYCLES - 1);

   logic [15:0] incoming;
   logic [15:0] sample;
   logic [3:0]  cnt;
   logic        match;
   logic        fire;

   logic [7:0]  lowBits;
   logic        isBlank;
   logic        isOneHot;
   logic        isValid;
   logic        isIllegal;
   logic [2:0]  idx;

   logic [6:0]  segField;
   logic [3:0]  glyphVal;
   logic        glyphOk;

   logic [7:0]  seen;
   logic [7:0]  seenNext;
   logic        frameHit;

   assign incoming = {anodes, segments, dp};
   assign match    = (incoming == sample);

   // The event is the single edge at which the dwell counter reaches its
   // saturation value; the sample being committed equals the held one.
   assign fire = match && (cnt == cntPre);

   // Sample register and saturating stability counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample <= 16'hFFFF;
         cnt    <= 4'd0;
      end else begin
         sample <= incoming;
         if (!match) begin
            cnt <= 4'd0;
         end else if (cnt != cntMax) begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   // Classify the held anode pattern: one low bit selects a digit, no low
   // bits is a blanking interval, anything else is an illegal drive.
   always_comb begin
      lowBits   = ~sample[15:8];
      isBlank   = (lowBits == 8'h00);
      isOneHot  = ((lowBits & (lowBits - 8'd1)) == 8'h00);
      isValid   = !isBlank && isOneHot;
      isIllegal = !isBlank && !isOneHot;
      idx       = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (lowBits[i]) begin
            idx = 3'(i);
         end
      end
   end

   // Translate the active-low g..a segment pattern into a hex nibble;
   // unrecognised glyphs yield zero and are flagged as not ok.
   always_comb begin
      segField = sample[7:1];
      glyphVal = 4'h0;
      glyphOk  = 1'b1;
      case (segField)
         7'h40:   glyphVal = 4'h0;
         7'h79:   glyphVal = 4'h1;
         7'h24:   glyphVal = 4'h2;
         7'h30:   glyphVal = 4'h3;
         7'h19:   glyphVal = 4'h4;
         7'h12:   glyphVal = 4'h5;
         7'h02:   glyphVal = 4'h6;
         7'h78:   glyphVal = 4'h7;
         7'h00:   glyphVal = 4'h8;
         7'h10:   glyphVal = 4'h9;
         7'h08:   glyphVal = 4'hA;
         7'h03:   glyphVal = 4'hB;
         7'h46:   glyphVal = 4'hC;
         7'h21:   glyphVal = 4'hD;
         7'h06:   glyphVal = 4'hE;
         7'h0E:   glyphVal = 4'hF;
         default: begin
            glyphVal = 4'h0;
            glyphOk  = 1'b0;
         end
      endcase
   end

   // A frame is complete when this capture fills the last missing digit.
   always_comb begin
      seenNext = seen | (8'd1 << idx);
      frameHit = fire && isValid && (seenNext == 8'hFF);
   end

   // Captured digit fields, updated only by a valid event.
   always_ff @(posedge clk) begin
      if (reset) begin
         digit_val <= 32'd0;
         digit_ok  <= 8'd0;
         dp_bits   <= 8'd0;
         cur_idx   <= 3'd0;
      end else if (fire && isValid) begin
         digit_val[4*idx +: 4] <= glyphVal;
         digit_ok[idx]         <= glyphOk;
         dp_bits[idx]          <= ~sample[0];
         cur_idx               <= idx;
      end
   end

   // Digit coverage tracking and the one-cycle frame pulse; coverage restarts
   // on the same edge that raises the pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         seen       <= 8'd0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frameHit;
         if (frameHit) begin
            seen <= 8'd0;
         end else if (fire && isValid) begin
            seen <= seenNext;
         end
      end
   end

   // Sticky error flag raised only by an illegal pattern that survived a
   // full dwell.
   always_ff @(posedge clk) begin
      if (reset) begin
         anode_err <= 1'b0;
      end else if (fire && isIllegal) begin
         anode_err <= 1'b1;
      end
   end

endmodule
